lsu_exec: RTL and testbench
===========================

# lsu_exec

Load/store execution unit for the out-of-order core, sitting between the load/store reservation station and the common data bus (CDB). It accepts one ready memory op from the reservation station and computes the effective address. For a load, it reads data memory, then aligns and extends the result. It arbitrates for the CDB and broadcasts the ROB index and value, which wakes waiting reservation-station entries. Stores are not written here: address and data are broadcast so the ROB can write memory at commit.

## Interface
- `ROB_ENTRY_WIDTH`, default `` `ROB_ENTRY_WIDTH `` (4): ROB tag width. Tag 0 means "no broadcast".
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `flush` in 1: mispredict/exception flush. Kills the in-flight op.
- `in_valid` in 1: reservation station presents a ready op.
- `in_ready` out 1: unit can accept this cycle.
- `Op_in` in 6: operation, `OP_LB/LH/LW/LBU/LHU/SB/SH/SW`.
- `Vj_in` in 32: base register value.
- `Vk_in` in 32: store data. Ignored for loads.
- `Imm_in` in 32: sign-extended offset.
- `Dest_in` in ROB_ENTRY_WIDTH: destination ROB tag, nonzero.
- `mem_req` out 1: data-memory read request. Held until ack.
- `mem_addr` out 32: word address, {ea[31:2],2'b00}.
- `mem_ack` in 1: read data valid this cycle.
- `mem_rdata` in 32: little-endian read word.
- `cdb_req` out 1: request CDB slot.
- `cdb_grant` in 1: CDB slot granted this cycle.
- `CDB_LSU_ROB_index` out ROB_ENTRY_WIDTH: broadcast tag. 0 when idle.
- `CDB_LSU_data` out 32: load result, or store data.
- `CDB_LSU_addr` out 32: effective address.
- `CDB_LSU_exc` out 1: misaligned access or illegal op.

## Operation
- FSM states: IDLE, MEM, WB.
- `in_ready = (state==IDLE) && !flush && !rst`.
- On accept (`in_valid && in_ready`), latch op, dest, `ea = Vj_in + Imm_in` (mod 2^32), and Vk_in.
- Misalignment rules:
  - H ops are misaligned when ea[0]=1.
  - W ops are misaligned when ea[1:0]≠0.
  - An op outside the 8 encodings is illegal.
- Transitions from IDLE:
  - Misaligned or illegal: go to WB with exc=1 and data=0. No memory access.
  - Store: go to WB with data = latched Vk (unmasked) and exc=0.
  - Load: go to MEM.
- MEM: `mem_req`=1. On `mem_ack`, register the aligned result and go to WB.
- Load alignment (sub-module `load_align`, combinational):
  - Select byte/half by ea[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- WB: `cdb_req`=1.
  - When `cdb_grant`=1, the tag, data, addr and exc outputs are driven that same cycle. Otherwise tag=0.
  - Next state is IDLE.
- Flush:
  - In IDLE or WB: go to IDLE immediately, with no broadcast that cycle.
  - In MEM: the bus cannot be cancelled. Mark the op killed, keep `mem_req` until `mem_ack`, then return to IDLE with no broadcast.
  - Flush concurrent with `in_valid`: the op is not accepted.
- `rst` mid-transaction: go to IDLE next edge and drop any pending read. The memory side must tolerate the abandoned request.

## Timing
- Reset values: state=IDLE. `in_ready`, `mem_req`, `cdb_req`, `CDB_LSU_exc` = 0. `mem_addr`, `CDB_LSU_data`, `CDB_LSU_addr` = 0. `CDB_LSU_ROB_index` = 0.
- Accept at cycle 0:
  - Store or exception: `cdb_req` at cycle 1.
  - Load: `mem_req` at cycle 1. With ack at cycle 1, `cdb_req` at cycle 2.
- Broadcast is combinational from grant, in the same cycle. `in_ready` returns the cycle after the broadcast.
- Peak throughput: one store per 2 cycles, one load per 3 cycles.
- `mem_addr` is stable while `mem_req`=1. WB data, addr and exc are stable while `cdb_req`=1.

## Structure
- `defines.vh` holds the `OP_*` load/store encodings, `` `ROB_ENTRY_WIDTH ``, and the FSM state localparams shared with the ROB.
- Sub-module `load_align`: inputs op, ea[1:0], rdata; output 32-bit result.

## Test plan
- LW, Vj=0x1000, Imm=8, mem_rdata=0xDEADBEEF, ack at cycle 1, grant at cycle 2 → mem_addr=0x1008; at cycle 2 index=Dest, data=0xDEADBEEF, exc=0.
- LB at ea=0x1003 with rdata=0x80FF_0000 → data=0xFFFFFF80. LBU at the same address → data=0x00000080.
- LH at ea=0x1001 → no `mem_req`; broadcast with exc=1, data=0, addr=0x1001 at cycle 1.
- SW, Vj=0x2000, Imm=-4, Vk=0x12345678 → no `mem_req`; broadcast with addr=0x1FFC, data=0x12345678.
- Load with grant withheld 3 cycles → `cdb_req` is held, outputs stable, index=0, `in_ready`=0 until the broadcast.
- Flush while in MEM, ack 2 cycles later → no broadcast, `in_ready`=1 the cycle after ack. Flush with `in_valid` in IDLE → not accepted.

Source files
------------

// File: rtl/lsu_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_exec_pkg
// Purpose  : Shared op encodings, FSM states and decode helpers for lsu_exec.
// Revision : 1.0  initial release
// ============================================================================
package lsu_exec_pkg;

  localparam int ROB_ENTRY_WIDTH_DEF = 4;

  localparam logic [5:0] OP_LB  = 6'h01;
  localparam logic [5:0] OP_LH  = 6'h02;
  localparam logic [5:0] OP_LW  = 6'h03;
  localparam logic [5:0] OP_LBU = 6'h04;
  localparam logic [5:0] OP_LHU = 6'h05;
  localparam logic [5:0] OP_SB  = 6'h06;
  localparam logic [5:0] OP_SH  = 6'h07;
  localparam logic [5:0] OP_SW  = 6'h08;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEM  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: is_legal = 1'b1;
      default:                                                  is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  // Byte ops can never be misaligned.
  function automatic logic is_misaligned(input logic [5:0] op, input logic [1:0] ea_lo);
    case (op)
      OP_LH, OP_LHU, OP_SH: is_misaligned = ea_lo[0];
      OP_LW, OP_SW:         is_misaligned = (ea_lo != 2'b00);
      default:              is_misaligned = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_exec_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_exec_if
// Purpose  : Reservation-station, data-memory and CDB signals of lsu_exec.
// Revision : 1.0  initial release
// ============================================================================
interface lsu_exec_if
  import lsu_exec_pkg::*;
#(
  parameter int ROB_ENTRY_WIDTH = ROB_ENTRY_WIDTH_DEF
);
  logic                       flush;
  logic                       in_valid;
  logic                       in_ready;
  logic [5:0]                 Op_in;
  logic [31:0]                Vj_in;
  logic [31:0]                Vk_in;
  logic [31:0]                Imm_in;
  logic [ROB_ENTRY_WIDTH-1:0] Dest_in;
  logic                       mem_req;
  logic [31:0]                mem_addr;
  logic                       mem_ack;
  logic [31:0]                mem_rdata;
  logic                       cdb_req;
  logic                       cdb_grant;
  logic [ROB_ENTRY_WIDTH-1:0] CDB_LSU_ROB_index;
  logic [31:0]                CDB_LSU_data;
  logic [31:0]                CDB_LSU_addr;
  logic                       CDB_LSU_exc;

  modport slave (
    input  flush, in_valid, Op_in, Vj_in, Vk_in, Imm_in, Dest_in,
    input  mem_ack, mem_rdata, cdb_grant,
    output in_ready, mem_req, mem_addr, cdb_req,
    output CDB_LSU_ROB_index, CDB_LSU_data, CDB_LSU_addr, CDB_LSU_exc
  );

  modport master (
    output flush, in_valid, Op_in, Vj_in, Vk_in, Imm_in, Dest_in,
    output mem_ack, mem_rdata, cdb_grant,
    input  in_ready, mem_req, mem_addr, cdb_req,
    input  CDB_LSU_ROB_index, CDB_LSU_data, CDB_LSU_addr, CDB_LSU_exc
  );
endinterface
`default_nettype wire

// File: rtl/lsu_exec_load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Selects and extends the addressed byte/half of a load word.
// Revision : 1.0  initial release
// ============================================================================
module load_align
  import lsu_exec_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata[7:0];
    case (ea_lo)
      2'd1:    w_byte = rdata[15:8];
      2'd2:    w_byte = rdata[23:16];
      2'd3:    w_byte = rdata[31:24];
      default: w_byte = rdata[7:0];
    endcase
    w_half = ea_lo[1] ? rdata[31:16] : rdata[15:0];

    result = 32'd0;
    case (op)
      OP_LB:   result = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  result = {24'd0, w_byte};
      OP_LH:   result = {{16{w_half[15]}}, w_half};
      OP_LHU:  result = {16'd0, w_half};
      OP_LW:   result = rdata;
      default: result = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_exec.sv
`default_nettype none
// ============================================================================
// Module   : lsu_exec
// Purpose  : Load/store execution unit: address generation, data-memory read,
//            load alignment and CDB broadcast.
// Revision : 1.0  initial release
// ============================================================================
module lsu_exec
  import lsu_exec_pkg::*;
#(
  parameter int ROB_ENTRY_WIDTH = ROB_ENTRY_WIDTH_DEF
)(
  input  logic         clk,
  input  logic         rst,
  lsu_exec_if.slave    bus
);

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [5:0]                 r_op;
  logic [ROB_ENTRY_WIDTH-1:0] r_dest;
  logic [31:0]                r_ea;
  logic [31:0]                r_data;
  logic                       r_exc;
  logic                       r_killed;

  logic [31:0] w_ea;
  logic        w_accept;
  logic        w_acc_exc;
  logic        w_acc_load;
  logic [31:0] w_load_data;

  assign w_ea       = bus.Vj_in + bus.Imm_in;
  assign w_accept   = bus.in_valid && bus.in_ready;
  assign w_acc_exc  = !is_legal(bus.Op_in) || is_misaligned(bus.Op_in, w_ea[1:0]);
  assign w_acc_load = is_load(bus.Op_in);

  load_align u_load_align (
    .op     (r_op),
    .ea_lo  (r_ea[1:0]),
    .rdata  (bus.mem_rdata),
    .result (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt           = r_state;
    bus.in_ready          = 1'b0;
    bus.mem_req           = 1'b0;
    bus.mem_addr          = 32'd0;
    bus.cdb_req           = 1'b0;
    bus.CDB_LSU_ROB_index = '0;
    bus.CDB_LSU_data      = 32'd0;
    bus.CDB_LSU_addr      = 32'd0;
    bus.CDB_LSU_exc       = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.in_ready = !bus.flush && !rst;
        if (w_accept)
          w_state_nxt = (w_acc_exc || !w_acc_load) ? S_WB : S_MEM;
      end
      S_MEM: begin
        // The read cannot be cancelled; a flushed op waits out its ack.
        bus.mem_req  = 1'b1;
        bus.mem_addr = {r_ea[31:2], 2'b00};
        if (bus.mem_ack)
          w_state_nxt = (r_killed || bus.flush) ? S_IDLE : S_WB;
      end
      S_WB: begin
        bus.CDB_LSU_data = r_data;
        bus.CDB_LSU_addr = r_ea;
        bus.CDB_LSU_exc  = r_exc;
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
        end else begin
          bus.cdb_req = 1'b1;
          if (bus.cdb_grant) begin
            bus.CDB_LSU_ROB_index = r_dest;
            w_state_nxt           = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op     <= 6'd0;
      r_dest   <= '0;
      r_ea     <= 32'd0;
      r_data   <= 32'd0;
      r_exc    <= 1'b0;
      r_killed <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op     <= bus.Op_in;
            r_dest   <= bus.Dest_in;
            r_ea     <= w_ea;
            r_exc    <= w_acc_exc;
            r_data   <= (w_acc_exc || w_acc_load) ? 32'd0 : bus.Vk_in;
            r_killed <= 1'b0;
          end
        end
        S_MEM: begin
          if (bus.flush)   r_killed <= 1'b1;
          if (bus.mem_ack) r_data   <= w_load_data;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_exec.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_exec
// Purpose  : Directed self-checking bench for lsu_exec.
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu_exec;
  import lsu_exec_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  lsu_exec_if #(.ROB_ENTRY_WIDTH(4)) bus ();

  lsu_exec #(.ROB_ENTRY_WIDTH(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic quiet_inputs();
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.Op_in     = 6'd0;
    bus.Vj_in     = 32'd0;
    bus.Vk_in     = 32'd0;
    bus.Imm_in    = 32'd0;
    bus.Dest_in   = 4'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'd0;
    bus.cdb_grant = 1'b0;
  endtask

  // Presents op at a negedge so it is accepted on the following posedge.
  task automatic present(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                         input logic [31:0] imm, input logic [3:0] dest);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.Op_in    = op;
    bus.Vj_in    = vj;
    bus.Vk_in    = vk;
    bus.Imm_in   = imm;
    bus.Dest_in  = dest;
  endtask

  // Full op with ack and grant at the earliest allowed cycles.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] vj,
                        input logic [31:0] vk, input logic [31:0] imm, input logic [3:0] dest,
                        input logic [31:0] rdata, input bit exp_mem,
                        input logic [31:0] exp_data, input bit exp_exc);
    logic [31:0] ea;
    ea = vj + imm;
    present(op, vj, vk, imm, dest);
    #1 chk({tag, ".in_ready"}, bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    if (exp_mem) begin
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = rdata;
      #1;
      chk({tag, ".mem_req"}, bus.mem_req, 1);
      chk({tag, ".mem_addr"}, bus.mem_addr, {ea[31:2], 2'b00});
      chk({tag, ".cdb_req_early"}, bus.cdb_req, 0);
      @(negedge clk);
      bus.mem_ack = 1'b0;
    end else begin
      #1 chk({tag, ".no_mem_req"}, bus.mem_req, 0);
    end
    bus.cdb_grant = 1'b1;
    #1;
    chk({tag, ".cdb_req"}, bus.cdb_req, 1);
    chk({tag, ".index"}, bus.CDB_LSU_ROB_index, dest);
    chk({tag, ".data"}, bus.CDB_LSU_data, exp_data);
    chk({tag, ".addr"}, bus.CDB_LSU_addr, ea);
    chk({tag, ".exc"}, bus.CDB_LSU_exc, exp_exc);
    @(negedge clk);
    bus.cdb_grant = 1'b0;
    #1;
    chk({tag, ".ready_after"}, bus.in_ready, 1);
    chk({tag, ".index_idle"}, bus.CDB_LSU_ROB_index, 0);
  endtask

  initial begin
    quiet_inputs();
    bus.in_valid = 1'b1;
    bus.Op_in    = OP_LW;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst.in_ready", bus.in_ready, 0);
    chk("rst.mem_req", bus.mem_req, 0);
    chk("rst.cdb_req", bus.cdb_req, 0);
    chk("rst.mem_addr", bus.mem_addr, 0);
    chk("rst.index", bus.CDB_LSU_ROB_index, 0);
    chk("rst.data", bus.CDB_LSU_data, 0);
    chk("rst.addr", bus.CDB_LSU_addr, 0);
    chk("rst.exc", bus.CDB_LSU_exc, 0);
    quiet_inputs();
    rst = 1'b0;
    #1 chk("post_rst.in_ready", bus.in_ready, 1);

    run_op("lw",   OP_LW,  32'h1000, 32'h0, 32'd8, 4'd5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0);
    run_op("lb",   OP_LB,  32'h1000, 32'h0, 32'd3, 4'd6, 32'h80FF0000, 1, 32'hFFFFFF80, 0);
    run_op("lbu",  OP_LBU, 32'h1000, 32'h0, 32'd3, 4'd7, 32'h80FF0000, 1, 32'h00000080, 0);
    run_op("lb1",  OP_LB,  32'h1000, 32'h0, 32'd1, 4'd8, 32'h80FF7F00, 1, 32'h0000007F, 0);
    run_op("lh2",  OP_LH,  32'h1000, 32'h0, 32'd2, 4'd9, 32'h80FF0000, 1, 32'hFFFF80FF, 0);
    run_op("lhu2", OP_LHU, 32'h1000, 32'h0, 32'd2, 4'd10, 32'h80FF0000, 1, 32'h000080FF, 0);
    run_op("lh0",  OP_LH,  32'h1000, 32'h0, 32'd0, 4'd11, 32'h1234F00D, 1, 32'hFFFFF00D, 0);
    run_op("lh_mis", OP_LH, 32'h1000, 32'h0, 32'd1, 4'd12, 32'h0, 0, 32'h0, 1);
    run_op("lw_mis", OP_LW, 32'h1000, 32'h0, 32'd2, 4'd13, 32'h0, 0, 32'h0, 1);
    run_op("sw",   OP_SW,  32'h2000, 32'h12345678, 32'hFFFFFFFC, 4'd14, 32'h0, 0, 32'h12345678, 0);
    run_op("sb",   OP_SB,  32'h2000, 32'hCAFEBABE, 32'd3, 4'd15, 32'h0, 0, 32'hCAFEBABE, 0);
    run_op("sh",   OP_SH,  32'h2000, 32'hA5A55A5A, 32'd2, 4'd1, 32'h0, 0, 32'hA5A55A5A, 0);
    run_op("sw_mis", OP_SW, 32'h2000, 32'h11111111, 32'd1, 4'd2, 32'h0, 0, 32'h0, 1);
    run_op("illegal", 6'h3F, 32'h3000, 32'h22222222, 32'd0, 4'd3, 32'h0, 0, 32'h0, 1);

    // Load with grant withheld for three cycles.
    present(OP_LW, 32'h4000, 32'h0, 32'd4, 4'd4);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold.cdb_req", bus.cdb_req, 1);
      chk("hold.index", bus.CDB_LSU_ROB_index, 0);
      chk("hold.data", bus.CDB_LSU_data, 32'h0BADF00D);
      chk("hold.addr", bus.CDB_LSU_addr, 32'h4004);
      chk("hold.in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.cdb_grant = 1'b1;
    #1;
    chk("hold.grant_index", bus.CDB_LSU_ROB_index, 4);
    chk("hold.grant_data", bus.CDB_LSU_data, 32'h0BADF00D);
    @(negedge clk);
    bus.cdb_grant = 1'b0;
    #1 chk("hold.ready_after", bus.in_ready, 1);

    // Flush while in MEM; ack arrives two cycles later.
    present(OP_LW, 32'h5000, 32'h0, 32'd0, 4'd6);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b1;
    bus.cdb_grant = 1'b1;
    #1 chk("fmem.mem_req0", bus.mem_req, 1);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    chk("fmem.mem_req1", bus.mem_req, 1);
    chk("fmem.mem_addr", bus.mem_addr, 32'h5000);
    chk("fmem.in_ready1", bus.in_ready, 0);
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77777777;
    #1 chk("fmem.mem_req2", bus.mem_req, 1);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("fmem.in_ready", bus.in_ready, 1);
    chk("fmem.cdb_req", bus.cdb_req, 0);
    chk("fmem.index", bus.CDB_LSU_ROB_index, 0);
    bus.cdb_grant = 1'b0;

    // Flush concurrent with in_valid in IDLE.
    present(OP_SW, 32'h6000, 32'h99, 32'd0, 4'd7);
    bus.flush = 1'b1;
    #1 chk("fidle.in_ready", bus.in_ready, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    #1;
    chk("fidle.cdb_req", bus.cdb_req, 0);
    chk("fidle.mem_req", bus.mem_req, 0);
    chk("fidle.in_ready_after", bus.in_ready, 1);

    // Flush in WB with a grant offered.
    present(OP_SW, 32'h7000, 32'h55, 32'd0, 4'd8);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b1;
    bus.cdb_grant = 1'b1;
    #1 chk("fwb.index", bus.CDB_LSU_ROB_index, 0);
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.cdb_grant = 1'b0;
    #1;
    chk("fwb.in_ready", bus.in_ready, 1);
    chk("fwb.cdb_req", bus.cdb_req, 0);

    // Reset mid-load abandons the read.
    present(OP_LW, 32'h8000, 32'h0, 32'd0, 4'd9);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("rmid.mem_req", bus.mem_req, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmid.mem_req_after", bus.mem_req, 0);
    chk("rmid.in_ready", bus.in_ready, 1);
    chk("rmid.mem_addr", bus.mem_addr, 0);

    // Back-to-back stores after recovery.
    run_op("sw2", OP_SW, 32'h0, 32'hFEEDFACE, 32'h10, 4'd11, 32'h0, 0, 32'hFEEDFACE, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
